sys_cmd_decoder: RTL
====================

Name: sys_cmd_decoder

Overview:
- Receive-side system controller: parses the byte stream from the UART RX into register-file write/read commands and ALU operations.
- Sequences the RF and the ALU for each command.
- Hands RF read data and ALU results to the TX-side controller through one-cycle send strobes with held data.
- Sits in the reference (system) clock domain, after the RX data synchroniser.

Parameters:
- WIDTH, 8, byte/data width; the ALU result is 2*WIDTH.
- ADDR, 4, register-file address width.
- TIMEOUT, 255, idle cycles before a partial frame is aborted (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- rx_data_in  in  WIDTH  received byte
- rx_data_valid_in  in  1  one-cycle strobe; rx_data_in is valid this cycle
- rf_wr_en_out  out  1  RF write strobe
- rf_rd_en_out  out  1  RF read strobe
- rf_addr_out  out  ADDR  RF address
- rf_wr_data_out  out  WIDTH  RF write data
- rf_rd_data_in  in  WIDTH  RF read data
- rf_rd_data_valid_in  in  1  RF read data valid
- alu_en_out  out  1  ALU enable
- alu_fun_out  out  4  ALU function
- alu_clk_gate_en_out  out  1  ALU clock-gate enable
- alu_out_in  in  2*WIDTH  ALU result
- alu_out_valid_in  in  1  ALU result valid
- uart_rf_send_out  out  1  one-cycle request to send RF data
- uart_rf_send_data_out  out  WIDTH  RF data, held until the next RF send
- uart_alu_send_out  out  1  one-cycle request to send the ALU result
- uart_alu_send_data_out  out  2*WIDTH  ALU result, held until the next ALU send

Behaviour:
- All outputs are registered. All outputs reset to 0 and the FSM resets to IDLE.

Frames (first byte is the command):
- 0xAA: RF write — bytes are addr, data.
- 0xBB: RF read — byte is addr.
- 0xCC: ALU with operands — bytes are A, B, fun.
- 0xDD: ALU without operands — byte is fun.
- A byte is consumed only in a cycle with rx_data_valid_in=1.
- Addresses use the low ADDR bits of the byte; fun uses the low 4 bits.

FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUN, ALU_WAIT.
- IDLE: 0xAA->WR_ADDR; 0xBB->RD_ADDR; 0xCC->OP_A; 0xDD->ALU_FUN. Any other byte is dropped and the FSM stays in IDLE.
- WR_ADDR: latch the address, go to WR_DATA.
- WR_DATA: the cycle after the data byte, rf_wr_en_out=1 for exactly 1 cycle with rf_addr_out and rf_wr_data_out valid. Go to IDLE.
- RD_ADDR: the cycle after the addr byte, rf_rd_en_out=1 for 1 cycle. Go to RD_WAIT.
- RD_WAIT: on rf_rd_data_valid_in, latch rf_rd_data_in into uart_rf_send_data_out. uart_rf_send_out=1 the following cycle, for 1 cycle. Go to IDLE.
- OP_A: write the byte to RF address 0 (1-cycle rf_wr_en_out). Go to OP_B.
- OP_B: write the byte to RF address 1. Go to ALU_FUN.
- ALU_FUN: latch fun. Go to ALU_WAIT.
- ALU_WAIT:
  - alu_clk_gate_en_out=1 for the whole state; alu_en_out=1 and alu_fun_out stable while waiting.
  - On alu_out_valid_in: latch alu_out_in into uart_alu_send_data_out, drop alu_en_out and the gate enable, pulse uart_alu_send_out the next cycle. Go to IDLE.
- rx bytes arriving in RD_WAIT or ALU_WAIT are dropped; no queueing.
- A result-valid input arriving outside its wait state is ignored.
- Send strobes are single-cycle. Send data never changes except on a new send.
- reset_n asserted mid-frame: immediate return to IDLE, all strobes/enables 0, partial frame discarded.

Optional Feature:
- Macro: SYS_CMD_TIMEOUT_EN.
- Defined:
  - An 8+-bit idle counter runs in WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B and ALU_FUN.
  - The counter clears on every rx_data_valid_in.
  - Reaching TIMEOUT cycles without a byte returns the FSM to IDLE with no RF/ALU side effects for the remaining bytes. Operand writes already done are kept.
  - Wait states are not timed out.
- Undefined: no counter; partial frames wait indefinitely.

Test Plan:
- Bytes AA,05,3C -> one rf_wr_en_out pulse with addr=5, data=0x3C; no other strobes.
- Bytes BB,05; rf_rd_data_valid_in two cycles after rf_rd_en_out with data 0x3C -> rf_rd_en_out pulse with addr=5, then uart_rf_send_out pulse with uart_rf_send_data_out=0x3C.
- Bytes CC,12,34,02:
  - RF writes expected: addr0=0x12 and addr1=0x34.
  - Respond with alu_out_in=0x0408 and valid 3 cycles later.
  - Required: alu_en_out=1 with alu_fun_out=2 and alu_clk_gate_en_out=1 until valid, then uart_alu_send_out pulse with data 0x0408.
- Bytes DD,01 -> no RF writes; alu_fun_out=1; ALU handshake as above.
- Byte 7F in IDLE, then AA,02,FF -> 7F ignored; single write of 0xFF to addr 2.
- Bytes AA,03 then reset_n low for 2 cycles, then 0x55 -> no RF write; FSM in IDLE; 0x55 dropped. With SYS_CMD_TIMEOUT_EN and TIMEOUT=10: bytes AA,03, 11 idle cycles, then 0x77 -> no write; 0x77 treated as a command byte and dropped.

Source files
------------

// File: rtl/sys_cmd_decoder.sv
// sys_cmd_decoder: receive-side system controller.
// Parses the RX byte stream into register-file write/read commands and ALU
// operations, sequences the RF and ALU, and hands results to the TX side
// through single-cycle send strobes with held data.
// Optional feature macro: SYS_CMD_TIMEOUT_EN (aborts stalled partial frames
// after TIMEOUT idle cycles).
module sys_cmd_decoder #(
  parameter int WIDTH   = 8,
  parameter int ADDR    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     rx_data_in,
  input  logic                 rx_data_valid_in,
  output logic                 rf_wr_en_out,
  output logic                 rf_rd_en_out,
  output logic [ADDR-1:0]      rf_addr_out,
  output logic [WIDTH-1:0]     rf_wr_data_out,
  input  logic [WIDTH-1:0]     rf_rd_data_in,
  input  logic                 rf_rd_data_valid_in,
  output logic                 alu_en_out,
  output logic [3:0]           alu_fun_out,
  output logic                 alu_clk_gate_en_out,
  input  logic [2*WIDTH-1:0]   alu_out_in,
  input  logic                 alu_out_valid_in,
  output logic                 uart_rf_send_out,
  output logic [WIDTH-1:0]     uart_rf_send_data_out,
  output logic                 uart_alu_send_out,
  output logic [2*WIDTH-1:0]   uart_alu_send_data_out
);

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    OP_A,
    OP_B,
    ALU_FUN,
    ALU_WAIT
  } state_t;

  localparam logic [WIDTH-1:0] CMD_RF_WR    = WIDTH'(8'hAA);
  localparam logic [WIDTH-1:0] CMD_RF_RD    = WIDTH'(8'hBB);
  localparam logic [WIDTH-1:0] CMD_ALU_OP   = WIDTH'(8'hCC);
  localparam logic [WIDTH-1:0] CMD_ALU_NOOP = WIDTH'(8'hDD);

  // Operand bytes of a 0xCC frame land in these fixed RF locations.
  localparam logic [ADDR-1:0] OPERAND_A_ADDR = ADDR'(0);
  localparam logic [ADDR-1:0] OPERAND_B_ADDR = ADDR'(1);

  // A zero timeout would make the abort compare wrap; reject it at elaboration.
  if (TIMEOUT < 1) begin : g_timeout_check
    $error("sys_cmd_decoder: TIMEOUT must be at least 1");
  end

  state_t state;
  logic   timeout_hit;

`ifdef SYS_CMD_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] idle_cnt;
  logic             timed_state;

  // Only partial-frame states are timed; the two wait states never abort.
  always_comb begin
    timed_state = 1'b0;
    case (state)
      WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, ALU_FUN: timed_state = 1'b1;
      default:                                        timed_state = 1'b0;
    endcase
    timeout_hit = timed_state && !rx_data_valid_in &&
                  (idle_cnt == CNT_W'(TIMEOUT - 1));
  end

  // Idle counter: clears on every received byte and whenever the FSM leaves
  // the timed states, so each frame byte restarts the budget.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt <= '0;
    end else if (!timed_state || rx_data_valid_in || timeout_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Frame parser and RF/ALU sequencer; strobes default low every cycle so each
  // one is a single-cycle pulse, while data outputs hold until rewritten.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                  <= IDLE;
      rf_wr_en_out           <= 1'b0;
      rf_rd_en_out           <= 1'b0;
      rf_addr_out            <= '0;
      rf_wr_data_out         <= '0;
      alu_en_out             <= 1'b0;
      alu_fun_out            <= '0;
      alu_clk_gate_en_out    <= 1'b0;
      uart_rf_send_out       <= 1'b0;
      uart_rf_send_data_out  <= '0;
      uart_alu_send_out      <= 1'b0;
      uart_alu_send_data_out <= '0;
    end else begin
      rf_wr_en_out      <= 1'b0;
      rf_rd_en_out      <= 1'b0;
      uart_rf_send_out  <= 1'b0;
      uart_alu_send_out <= 1'b0;

      if (timeout_hit) begin
        // Abandon the partial frame; any operand writes already issued stay.
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (rx_data_valid_in) begin
              case (rx_data_in)
                CMD_RF_WR:    state <= WR_ADDR;
                CMD_RF_RD:    state <= RD_ADDR;
                CMD_ALU_OP:   state <= OP_A;
                CMD_ALU_NOOP: state <= ALU_FUN;
                default:      state <= IDLE;
              endcase
            end
          end

          WR_ADDR: begin
            if (rx_data_valid_in) begin
              rf_addr_out <= rx_data_in[ADDR-1:0];
              state       <= WR_DATA;
            end
          end

          WR_DATA: begin
            if (rx_data_valid_in) begin
              rf_wr_data_out <= rx_data_in;
              rf_wr_en_out   <= 1'b1;
              state          <= IDLE;
            end
          end

          RD_ADDR: begin
            if (rx_data_valid_in) begin
              rf_addr_out  <= rx_data_in[ADDR-1:0];
              rf_rd_en_out <= 1'b1;
              state        <= RD_WAIT;
            end
          end

          RD_WAIT: begin
            if (rf_rd_data_valid_in) begin
              uart_rf_send_data_out <= rf_rd_data_in;
              uart_rf_send_out      <= 1'b1;
              state                 <= IDLE;
            end
          end

          OP_A: begin
            if (rx_data_valid_in) begin
              rf_addr_out    <= OPERAND_A_ADDR;
              rf_wr_data_out <= rx_data_in;
              rf_wr_en_out   <= 1'b1;
              state          <= OP_B;
            end
          end

          OP_B: begin
            if (rx_data_valid_in) begin
              rf_addr_out    <= OPERAND_B_ADDR;
              rf_wr_data_out <= rx_data_in;
              rf_wr_en_out   <= 1'b1;
              state          <= ALU_FUN;
            end
          end

          ALU_FUN: begin
            if (rx_data_valid_in) begin
              alu_fun_out         <= rx_data_in[3:0];
              alu_en_out          <= 1'b1;
              alu_clk_gate_en_out <= 1'b1;
              state               <= ALU_WAIT;
            end
          end

          ALU_WAIT: begin
            if (alu_out_valid_in) begin
              uart_alu_send_data_out <= alu_out_in;
              uart_alu_send_out      <= 1'b1;
              alu_en_out             <= 1'b0;
              alu_clk_gate_en_out    <= 1'b0;
              state                  <= IDLE;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
